// File: rtl/dram_model_pkg.sv
// Shared constants for the dram_model external-memory model: fill modes,
// FSM encoding and the LFSR used for read-ready stalls.
package dram_model_pkg;

  localparam int FILL_NONE  = 0;
  localparam int FILL_CONST = 1;
  localparam int FILL_ADDR  = 2;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Fibonacci step: taps 8,6,5,4 feed back into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-response pipeline: RD_LAT stages of valid+data with synchronous flush.
// Data is forced to zero whenever the matching valid is low.
module dram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [RD_LAT-1:0] r_vld;
  logic [DATA_W-1:0] r_dat [RD_LAT];

  always_ff @(posedge i_clk) begin
    if (i_flush) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_dat[0] <= i_valid ? i_data : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_valid = r_vld[RD_LAT-1];
  assign o_data  = r_vld[RD_LAT-1] ? r_dat[RD_LAT-1] : '0;

endmodule

// File: rtl/dram_model.sv
// Cycle-accurate external memory: power-up fill, fixed-latency pipelined reads,
// unstalled writes and optional LFSR-driven read-ready stalls.
module dram_model
  import dram_model_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 10,
  parameter int              RD_LAT    = 2,
  parameter int              FILL_MODE = 2,
  parameter logic [DATA_W-1:0] FILL_VAL = 'h01,
  parameter bit              STALL_EN  = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_rd_ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic [7:0]        r_lfsr;

  logic              w_fill_last;
  logic              w_rd_ready;
  logic              w_rd_acc;
  logic              w_we;
  logic [ADDR_W-1:0] w_wa;
  logic [DATA_W-1:0] w_wd;
  logic [DATA_W-1:0] w_addr_word;
  logic [DATA_W-1:0] w_rd_word;

  generate
    if (ADDR_W >= DATA_W) begin : g_addr_trunc
      assign w_addr_word = r_fill_cnt[DATA_W-1:0];
    end else begin : g_addr_zext
      assign w_addr_word = {{(DATA_W-ADDR_W){1'b0}}, r_fill_cnt};
    end
  endgenerate

  assign w_fill_last = &r_fill_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_rd_ready  = 1'b0;
    w_we        = 1'b0;
    w_wa        = i_wr_addr;
    w_wd        = i_wr_data;
    case (r_state)
      ST_FILL: begin
        w_we = 1'b1;
        w_wa = r_fill_cnt;
        w_wd = (FILL_MODE == FILL_CONST) ? FILL_VAL : w_addr_word;
        if (w_fill_last) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_we       = i_wr_en;
        w_rd_ready = !(STALL_EN && (r_lfsr[1:0] == 2'b00));
      end
    endcase
  end

  assign w_rd_acc = i_rd_en & w_rd_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= (FILL_MODE != FILL_NONE) ? ST_FILL : ST_RUN;
      r_fill_cnt <= '0;
      r_lfsr     <= LFSR_SEED;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_FILL) r_fill_cnt <= r_fill_cnt + 1'b1;
      if (r_state == ST_RUN)  r_lfsr     <= lfsr_next(r_lfsr);
    end
  end

  // Array has no reset; the fill engine is what initialises it.
  always_ff @(posedge i_clk) begin
    if (i_rst && w_we) r_mem[w_wa] <= w_wd;
  end

  // Combinational array read ahead of the write edge gives read-before-write.
  assign w_rd_word = r_mem[i_rd_addr];

  dram_rd_pipe #(
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .i_clk  (i_clk),
    .i_flush(!i_rst),
    .i_valid(w_rd_acc),
    .i_data (w_rd_word),
    .o_valid(o_rd_valid),
    .o_data (o_rd_data)
  );

  assign o_rd_ready = w_rd_ready;

endmodule

// File: tb/tb_dram_model.sv
// Directed bench for dram_model: fill timing, read latency, read-before-write,
// back-to-back reads, mid-flight reset and LFSR stall behaviour.
module tb_dram_model;

  logic       clk;
  logic       a_rst, a_wr_en, a_rd_en;
  logic [9:0] a_wr_addr, a_rd_addr;
  logic [7:0] a_wr_data, a_rd_data;
  logic       a_rd_valid, a_rd_ready;

  logic       b_rst, b_wr_en, b_rd_en;
  logic [9:0] b_wr_addr, b_rd_addr;
  logic [7:0] b_wr_data, b_rd_data;
  logic       b_rd_valid, b_rd_ready;

  int checks = 0;
  int errors = 0;

  dram_model #(.DATA_W(8), .ADDR_W(10), .RD_LAT(2), .FILL_MODE(2),
               .FILL_VAL(8'h01), .STALL_EN(1'b0)) u_dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr),
    .i_wr_data(a_wr_data), .i_rd_en(a_rd_en), .i_rd_addr(a_rd_addr),
    .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid), .o_rd_ready(a_rd_ready)
  );

  dram_model #(.DATA_W(8), .ADDR_W(10), .RD_LAT(2), .FILL_MODE(1),
               .FILL_VAL(8'h01), .STALL_EN(1'b1)) u_dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr),
    .i_wr_data(b_wr_data), .i_rd_en(b_rd_en), .i_rd_addr(b_rd_addr),
    .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .o_rd_ready(b_rd_ready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    a_rst = 1'b0; b_rst = 1'b0;
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_en = 1'b0; a_rd_addr = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_en = 1'b0; b_rd_addr = '0;
    repeat (3) @(negedge clk);
    checks++; if (a_rd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", a_rd_ready); end
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", a_rd_valid); end
    checks++; if (a_rd_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", a_rd_data); end
    checks++; if (b_rd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_b got %b expected 0", b_rd_ready); end
  endtask

  // Releases reset at the current negedge and counts not-ready cycles.
  task automatic test_fill();
    int cnt = 0;
    a_rst = 1'b1;
    while (a_rd_ready !== 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 1024) begin errors++; $display("FAIL fill_len got %0d expected 1024", cnt); end
    a_rd_en = 1'b1; a_rd_addr = 10'h155;
    @(negedge clk);
    a_rd_en = 1'b0;
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL fill_rd_early got %b expected 0", a_rd_valid); end
    @(negedge clk);
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h55) begin
      errors++; $display("FAIL fill_rd_155 got v=%b d=%h expected v=1 d=55", a_rd_valid, a_rd_data); end
    @(negedge clk);
    checks++; if (a_rd_valid !== 1'b0 || a_rd_data !== 8'h00) begin
      errors++; $display("FAIL fill_rd_after got v=%b d=%h expected v=0 d=00", a_rd_valid, a_rd_data); end
  endtask

  task automatic test_write_read();
    a_wr_en = 1'b1; a_wr_addr = 10'd5; a_wr_data = 8'h3C;
    @(negedge clk);
    a_wr_en = 1'b0; a_rd_en = 1'b1; a_rd_addr = 10'd5;
    @(negedge clk);
    a_rd_en = 1'b0;
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_early got %b expected 0", a_rd_valid); end
    @(negedge clk);
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h3C) begin
      errors++; $display("FAIL wr_rd_data got v=%b d=%h expected v=1 d=3c", a_rd_valid, a_rd_data); end
    @(negedge clk);
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_pulse got %b expected 0", a_rd_valid); end
  endtask

  task automatic test_read_before_write();
    a_wr_en = 1'b1; a_wr_addr = 10'd7; a_wr_data = 8'hEE;
    a_rd_en = 1'b1; a_rd_addr = 10'd7;
    @(negedge clk);
    a_wr_en = 1'b0;
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL rbw_early got %b expected 0", a_rd_valid); end
    @(negedge clk);
    a_rd_en = 1'b0;
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h07) begin
      errors++; $display("FAIL rbw_old got v=%b d=%h expected v=1 d=07", a_rd_valid, a_rd_data); end
    @(negedge clk);
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hEE) begin
      errors++; $display("FAIL rbw_new got v=%b d=%h expected v=1 d=ee", a_rd_valid, a_rd_data); end
    @(negedge clk);
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL rbw_end got %b expected 0", a_rd_valid); end
  endtask

  task automatic test_back_to_back();
    logic       exp_v;
    logic [7:0] exp_d;
    for (int k = 0; k < 7; k++) begin
      exp_v = (k >= 2 && k <= 5);
      exp_d = exp_v ? 8'(k - 2) : 8'h00;
      checks++;
      if (a_rd_valid !== exp_v || a_rd_data !== exp_d) begin
        errors++;
        $display("FAIL b2b_cyc%0d got v=%b d=%h expected v=%b d=%h", k, a_rd_valid, a_rd_data, exp_v, exp_d);
      end
      a_rd_en   = (k < 4);
      a_rd_addr = 10'(k);
      @(negedge clk);
    end
    a_rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    int spurious = 0;
    a_rd_en = 1'b1; a_rd_addr = 10'h010;
    @(negedge clk);
    a_rd_en = 1'b0; a_rst = 1'b0;
    @(negedge clk);
    checks++; if (a_rd_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got %b expected 0", a_rd_ready); end
    a_rst = 1'b1;
    while (a_rd_ready !== 1'b1 && cnt < 2000) begin
      if (a_rd_valid !== 1'b0) spurious++;
      cnt++;
      @(negedge clk);
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rst_mid_valid got %0d pulses expected 0", spurious); end
    checks++; if (cnt != 1024) begin errors++; $display("FAIL rst_mid_refill_len got %0d expected 1024", cnt); end
    // Address 5 held 3C before reset; refill must restore the pattern value.
    a_rd_en = 1'b1; a_rd_addr = 10'd5;
    @(negedge clk);
    a_rd_addr = 10'd7;
    @(negedge clk);
    a_rd_en = 1'b0;
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h05) begin
      errors++; $display("FAIL rst_mid_refill5 got v=%b d=%h expected v=1 d=05", a_rd_valid, a_rd_data); end
    @(negedge clk);
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h07) begin
      errors++; $display("FAIL rst_mid_refill7 got v=%b d=%h expected v=1 d=07", a_rd_valid, a_rd_data); end
  endtask

  task automatic test_stall();
    int   cnt = 0;
    int   n_acc = 0, n_vld = 0, bad_rdy = 0, bad_vld = 0, bad_dat = 0;
    logic [7:0] lfsr_m = 8'hA5;
    logic acc_h [0:519];
    logic exp_rdy, exp_vld;
    b_rst = 1'b1;
    while (b_rd_ready !== 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 1024) begin errors++; $display("FAIL stall_fill_len got %0d expected 1024", cnt); end
    for (int t = 0; t < 504; t++) begin
      exp_rdy  = (lfsr_m[1:0] != 2'b00);
      acc_h[t] = (t < 500) && exp_rdy;
      exp_vld  = (t >= 2) ? acc_h[t-2] : 1'b0;
      if (b_rd_ready !== exp_rdy) bad_rdy++;
      if (b_rd_valid !== exp_vld) bad_vld++;
      if (b_rd_valid === 1'b1 && b_rd_data !== 8'h01) bad_dat++;
      if (acc_h[t]) n_acc++;
      if (b_rd_valid === 1'b1) n_vld++;
      b_rd_en   = (t < 500);
      b_rd_addr = 10'(t);
      lfsr_m    = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
      @(negedge clk);
    end
    b_rd_en = 1'b0;
    checks++; if (bad_rdy != 0) begin errors++; $display("FAIL stall_ready_pattern got %0d wrong cycles expected 0", bad_rdy); end
    checks++; if (bad_vld != 0) begin errors++; $display("FAIL stall_valid_timing got %0d wrong cycles expected 0", bad_vld); end
    checks++; if (bad_dat != 0) begin errors++; $display("FAIL stall_data got %0d bad words expected 0", bad_dat); end
    checks++; if (n_vld != n_acc) begin errors++; $display("FAIL stall_count got %0d valids expected %0d", n_vld, n_acc); end
    checks++; if (n_acc == 0 || n_acc >= 500) begin
      errors++; $display("FAIL stall_present got %0d accepts expected between 1 and 499", n_acc); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
